// File: rtl/seq_tx_11011_if.sv
`timescale 1ns / 1ps
// Payload load handshake for the 11011 frame transmitter.
interface seq_tx_11011_if #(
  parameter int unsigned DATA_W = 8
);
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;

  // Word source side.
  modport master (
    output load_valid,
    output load_data,
    input  load_ready
  );

  // Transmitter side.
  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready
  );
endinterface

// File: rtl/seq_tx_11011.sv
`timescale 1ns / 1ps
// Serial frame transmitter: sync marker 11011, payload MSB first, then a zero gap.
module seq_tx_11011 #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned GAP_LEN = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_tx_11011_if.slave load,
  output logic          ser_out,
  output logic          ser_en,
  output logic          busy,
  output logic          frame_done
);

  localparam int unsigned SyncLen = 5;
  // Marker padded to 8 bits so any 3-bit index stays in range.
  localparam logic [7:0] SyncTab = 8'b000_11011;
  localparam int unsigned MaxDs  = (DATA_W > SyncLen) ? DATA_W : SyncLen;
  localparam int unsigned CntMax = (GAP_LEN > MaxDs) ? GAP_LEN : MaxDs;
  localparam int unsigned CntW   = $clog2(CntMax);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StSync = 2'b01,
    StData = 2'b10,
    StGap  = 2'b11
  } state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [DATA_W-1:0] shreg_q;

  logic       sync_last;
  logic       data_last;
  logic       data_pen;
  logic       gap_last;
  logic [2:0] sync_idx;

  // Phase-end decodes and the index of the next marker bit to drive.
  always_comb begin
    sync_last = (cnt_q == CntW'(SyncLen - 1));
    data_last = (cnt_q == CntW'(DATA_W - 1));
    data_pen  = ((cnt_q + CntW'(1)) == CntW'(DATA_W - 1));
    gap_last  = (cnt_q == CntW'(GAP_LEN - 1));
    // Bit k is on the line now; bit k+1 sits at position 3-k of the marker.
    sync_idx  = 3'd3 - cnt_q[2:0];
  end

  assign load.load_ready = (state_q == StIdle);
  assign busy            = (state_q != StIdle);

  // Frame FSM; serial outputs are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      shreg_q    <= '0;
      ser_out    <= 1'b0;
      ser_en     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (load.load_valid) begin
            state_q <= StSync;
            cnt_q   <= '0;
            shreg_q <= load.load_data;
            ser_out <= SyncTab[4];
            ser_en  <= 1'b1;
          end
        end
        StSync: begin
          if (sync_last) begin
            state_q    <= StData;
            cnt_q      <= '0;
            ser_out    <= shreg_q[DATA_W-1];
            shreg_q    <= shreg_q << 1;
            frame_done <= (DATA_W == 1);
          end else begin
            cnt_q   <= cnt_q + CntW'(1);
            ser_out <= SyncTab[sync_idx];
          end
        end
        StData: begin
          if (data_last) begin
            state_q    <= StGap;
            cnt_q      <= '0;
            ser_out    <= 1'b0;
            ser_en     <= 1'b0;
            frame_done <= 1'b0;
          end else begin
            cnt_q      <= cnt_q + CntW'(1);
            ser_out    <= shreg_q[DATA_W-1];
            shreg_q    <= shreg_q << 1;
            frame_done <= data_pen;
          end
        end
        StGap: begin
          if (gap_last) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q    <= StIdle;
          cnt_q      <= '0;
          ser_out    <= 1'b0;
          ser_en     <= 1'b0;
          frame_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_tx_11011.sv
`timescale 1ns / 1ps
// Self-checking bench for seq_tx_11011: table vectors, corner sequences, random traffic.
module tb_seq_tx_11011;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned GAP_LEN = 2;

  logic clk;
  logic rst_n;
  logic ser_out;
  logic ser_en;
  logic busy;
  logic frame_done;

  seq_tx_11011_if #(.DATA_W(DATA_W)) tx_if ();

  seq_tx_11011 #(
    .DATA_W (DATA_W),
    .GAP_LEN(GAP_LEN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (tx_if.slave),
    .ser_out   (ser_out),
    .ser_en    (ser_en),
    .busy      (busy),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Receive-side 11011 detector: pulses the cycle after the marker's last bit.
  logic [3:0] det_hist;
  logic       det;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      det_hist <= '0;
      det      <= 1'b0;
    end else begin
      det_hist <= {det_hist[2:0], ser_out};
      det      <= ({det_hist, ser_out} == 5'b11011);
    end
  end

  // Reference model: the whole frame is laid out as a per-cycle list on acceptance.
  typedef struct packed {
    logic so;
    logic en;
    logic fd;
  } bit_t;

  bit_t exp_q[$];

  typedef struct {
    logic [7:0]  data;
    logic [12:0] stream;
  } vec_t;

  vec_t vecs[4];

  int n_cmp = 0;
  int n_err = 0;
  int tick_no = 0;
  logic [4:0] last_act;  // {ser_out, ser_en, frame_done, busy, load_ready}
  logic       last_det;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (tick %0d): got %0h, required %0h", name, tick_no, act, exp);
    end
  endtask

  function automatic logic [4:0] model_out();
    if (exp_q.size() > 0) return {exp_q[0].so, exp_q[0].en, exp_q[0].fd, 1'b1, 1'b0};
    return 5'b00001;
  endfunction

  function automatic void push_frame(input logic [DATA_W-1:0] data);
    logic [4:0] sync_word;
    sync_word = 5'b11011;
    for (int i = 4; i >= 0; i--) exp_q.push_back('{so: sync_word[i], en: 1'b1, fd: 1'b0});
    for (int i = DATA_W - 1; i >= 0; i--) exp_q.push_back('{so: data[i], en: 1'b1, fd: (i == 0)});
    for (int i = 0; i < GAP_LEN; i++) exp_q.push_back('{so: 1'b0, en: 1'b0, fd: 1'b0});
  endfunction

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic tick(input string tag);
    @(negedge clk);
    last_act = {ser_out, ser_en, frame_done, busy, tx_if.load_ready};
    last_det = det;
    check(tag, 32'(last_act), 32'(model_out()));
    @(posedge clk);
    if (!rst_n) exp_q.delete();
    else if (exp_q.size() > 0) void'(exp_q.pop_front());
    else if (tx_if.load_valid) push_frame(tx_if.load_data);
    tick_no++;
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    logic [12:0] stream;
    int en_cnt, fd_cnt, fd_pos;
    tx_if.load_valid = 1'b1;
    tx_if.load_data  = v.data;
    tick("tbl_accept");
    tx_if.load_valid = 1'b0;
    tx_if.load_data  = ~v.data;  // changes after acceptance must not leak into the frame
    stream = '0;
    en_cnt = 0;
    fd_cnt = 0;
    fd_pos = -1;
    for (int c = 1; c <= 15; c++) begin
      tick("tbl_frame");
      if (c <= 13) stream = {stream[11:0], last_act[4]};
      en_cnt += int'(last_act[3]);
      if (last_act[2]) begin
        fd_cnt++;
        fd_pos = c;
      end
    end
    check("tbl_stream", 32'(stream), 32'(v.stream));
    check("tbl_en_count", 32'(en_cnt), 32'd13);
    check("tbl_fd_pos", 32'(fd_pos), 32'd13);
    check("tbl_fd_count", 32'(fd_cnt), 32'd1);
    tick("tbl_c16");
    check("tbl_ready_c16", 32'(last_act[0]), 32'd1);
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, stream: 13'b11011_10100101};
    vecs[1] = '{data: 8'hFF, stream: 13'b11011_11111111};
    vecs[2] = '{data: 8'h00, stream: 13'b11011_00000000};
    vecs[3] = '{data: 8'h3C, stream: 13'b11011_00111100};

    rst_n            = 1'b0;
    tx_if.load_valid = 1'b0;
    tx_if.load_data  = 8'hA5;
    @(posedge clk);
    #1;

    // Reset: valid toggling must not start a frame.
    for (int i = 0; i < 4; i++) begin
      tx_if.load_valid = ~tx_if.load_valid;
      tick("reset_hold");
    end
    tx_if.load_valid = 1'b0;
    rst_n = 1'b1;
    tick("reset_release");
    check("reset_ready", 32'(last_act[0]), 32'd1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back: valid held, second sync 16 cycles after the first.
    begin
      int rise1, rise2;
      logic prev_en;
      rise1 = -1;
      rise2 = -1;
      prev_en = 1'b0;
      tx_if.load_valid = 1'b1;
      tx_if.load_data  = 8'hFF;
      tick("b2b_accept");
      tx_if.load_data = 8'h00;
      for (int c = 1; c <= 31; c++) begin
        tick("b2b_frame");
        if (last_act[3] && !prev_en) begin
          if (rise1 < 0) rise1 = c;
          else if (rise2 < 0) rise2 = c;
        end
        prev_en = last_act[3];
      end
      tx_if.load_valid = 1'b0;
      tick("b2b_idle");
      check("b2b_first_sync", 32'(rise1), 32'd1);
      check("b2b_period", 32'(rise2 - rise1), 32'd16);
    end

    // Busy-ignore: a pulse during DATA does not start a second frame.
    begin
      logic [12:0] stream;
      int rises;
      logic prev_en;
      stream = '0;
      rises = 0;
      prev_en = 1'b0;
      tx_if.load_valid = 1'b1;
      tx_if.load_data  = 8'hA5;
      tick("ign_accept");
      tx_if.load_valid = 1'b0;
      for (int c = 1; c <= 20; c++) begin
        if (c == 8) begin
          tx_if.load_valid = 1'b1;
          tx_if.load_data  = 8'h3C;
        end
        tick("ign_frame");
        tx_if.load_valid = 1'b0;
        if (c <= 13) stream = {stream[11:0], last_act[4]};
        if (last_act[3] && !prev_en) rises++;
        prev_en = last_act[3];
      end
      check("ign_stream", 32'(stream), 32'(13'b11011_10100101));
      check("ign_frames", 32'(rises), 32'd1);
    end

    // Mid-frame reset during the third sync bit.
    tx_if.load_valid = 1'b1;
    tx_if.load_data  = 8'hFF;
    tick("rst_accept");
    tx_if.load_valid = 1'b0;
    tick("rst_sync1");
    tick("rst_sync2");
    check("rst_pre_en", 32'(ser_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async_out", 32'({ser_out, ser_en, frame_done, busy, tx_if.load_ready}),
          32'(5'b00001));
    exp_q.delete();
    tick("rst_held");
    tick("rst_held");
    rst_n = 1'b1;
    tick("rst_idle");
    check("rst_ready", 32'(last_act[0]), 32'd1);
    run_vec(vecs[0]);

    // Loopback into the detector: one hit per frame, the cycle after sync bit 5.
    for (int f = 0; f < 3; f++) begin
      int det_cnt, det_pos;
      det_cnt = 0;
      det_pos = -1;
      tx_if.load_valid = 1'b1;
      tx_if.load_data  = 8'h00;
      tick("loop_accept");
      tx_if.load_valid = 1'b0;
      for (int c = 1; c <= 16; c++) begin
        tick("loop_frame");
        if (last_det) begin
          det_cnt++;
          det_pos = c;
        end
      end
      check("loop_det_count", 32'(det_cnt), 32'd1);
      check("loop_det_pos", 32'(det_pos), 32'd6);
    end

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      tx_if.load_valid = ($urandom_range(3) == 0);
      tx_if.load_data  = 8'($urandom);
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
